// File: rtl/aes_iter_encrypt_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative encryptor.
package aes_iter_encrypt_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_RSV = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Sliding key-expansion window; element 0 is the oldest word, 7 the newest.
  typedef logic [7:0][31:0] kwin_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Generic GF(2^8) product, shift-and-add with reduction by xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // S-box: field inverse followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] idx);
    logic [7:0] r;
    case (idx)
      6'd1:    r = 8'h01;
      6'd2:    r = 8'h02;
      6'd3:    r = 8'h04;
      6'd4:    r = 8'h08;
      6'd5:    r = 8'h10;
      6'd6:    r = 8'h20;
      6'd7:    r = 8'h40;
      6'd8:    r = 8'h80;
      6'd9:    r = 8'h1b;
      6'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Reserved key length behaves as AES-256.
  function automatic key_len_e norm_kl(input logic [1:0] kl);
    key_len_e r;
    case (kl)
      2'd0:    r = KL_128;
      2'd1:    r = KL_192;
      default: r = KL_256;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    logic [3:0] r;
    case (kl)
      KL_128:  r = 4'd10;
      KL_192:  r = 4'd12;
      default: r = 4'd14;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] nk_of(input key_len_e kl);
    logic [5:0] r;
    case (kl)
      KL_128:  r = 6'd4;
      KL_192:  r = 6'd6;
      default: r = 6'd8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
module aes_iter_encrypt_round
  import aes_iter_encrypt_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];

  // Byte n of the state is bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
  always_comb begin
    sb_s      = '{default: 8'h00};
    sr_s      = '{default: 8'h00};
    mc_s      = '{default: 8'h00};
    state_out = 128'h0;
    for (int n = 0; n < 16; n++) begin
      sb_s[n] = sbox(state_in[127-8*n -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c+0] = gmul2(sr_s[4*c+0]) ^ gmul3(sr_s[4*c+1]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+1] = sr_s[4*c+0] ^ gmul2(sr_s[4*c+1]) ^ gmul3(sr_s[4*c+2]) ^ sr_s[4*c+3];
      mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ gmul2(sr_s[4*c+2]) ^ gmul3(sr_s[4*c+3]);
      mc_s[4*c+3] = gmul3(sr_s[4*c+0]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ gmul2(sr_s[4*c+3]);
    end
    for (int n = 0; n < 16; n++) begin
      state_out[127-8*n -: 8] = (last ? sr_s[n] : mc_s[n]) ^ rkey[127-8*n -: 8];
    end
  end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128/192/256 encryptor, UNROLL rounds per clock, on-the-fly key expansion.
module aes_iter_encrypt
  import aes_iter_encrypt_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter bit DBG_EN = 1'b1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   key_len,
  input  logic [127:0] plain,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state,
  output logic [127:0] dbg_rkey
);

  // Next expanded word w[idx] from a window holding w[idx-8..idx-1].
  function automatic logic [31:0] next_word(input kwin_t w, input logic [5:0] idx, input key_len_e kl);
    logic [31:0] old_w;
    logic [31:0] t;
    logic [5:0]  rc;
    logic [5:0]  ph;
    case (kl)
      KL_128: begin
        old_w = w[4];
        rc    = {2'b00, idx[5:2]};
        ph    = {4'b0000, idx[1:0]};
      end
      KL_192: begin
        old_w = w[2];
        rc    = idx / 6'd6;
        ph    = idx % 6'd6;
      end
      default: begin
        old_w = w[0];
        rc    = {3'b000, idx[5:3]};
        ph    = {3'b000, idx[2:0]};
      end
    endcase
    if (ph == 6'd0)                    t = sub_word(rot_word(w[7])) ^ {rcon(rc), 24'h000000};
    else if (kl == KL_256 && ph == 6'd4) t = sub_word(w[7]);
    else                               t = w[7];
    return old_w ^ t;
  endfunction

  // Four new words per round, shifted into the newest end of the window.
  function automatic kwin_t gen4(input kwin_t w, input logic [5:0] idx, input key_len_e kl);
    kwin_t nw;
    nw = w;
    for (int j = 0; j < 4; j++) begin
      nw = {next_word(nw, idx + 6'(j), kl), nw[7:1]};
    end
    return nw;
  endfunction

  // After a round's words are generated, w[4r] sits at window slot 8-Nk.
  function automatic logic [127:0] round_key(input kwin_t w, input key_len_e kl);
    logic [127:0] rk;
    case (kl)
      KL_128:  rk = {w[4], w[5], w[6], w[7]};
      KL_192:  rk = {w[2], w[3], w[4], w[5]};
      default: rk = {w[0], w[1], w[2], w[3]};
    endcase
    return rk;
  endfunction

  // Cipher key words w0..w(Nk-1) placed so the newest key word lands in slot 7.
  function automatic kwin_t load_window(input logic [255:0] k, input key_len_e kl);
    kwin_t       w;
    logic [31:0] kw [8];
    w = '0;
    for (int j = 0; j < 8; j++) kw[j] = k[255-32*j -: 32];
    case (kl)
      KL_128:  for (int j = 0; j < 4; j++) w[j+4] = kw[j];
      KL_192:  for (int j = 0; j < 6; j++) w[j+2] = kw[j];
      default: for (int j = 0; j < 8; j++) w[j]   = kw[j];
    endcase
    return w;
  endfunction

  fsm_e         fsm_r;
  fsm_e         fsm_nxt_s;
  logic [127:0] state_r;
  kwin_t        win_r;
  logic [5:0]   widx_r;
  logic [3:0]   rnd_r;
  logic [3:0]   nr_r;
  key_len_e     kl_r;
  logic [127:0] cipher_r;
  logic [127:0] rkey_dbg_r;
  logic [3:0]   rnd_nxt_s;
  logic         finish_s;
  key_len_e     kl_in_s;

  assign kl_in_s   = norm_kl(key_len);
  assign rnd_nxt_s = rnd_r + 4'(UNROLL);
  assign finish_s  = (rnd_nxt_s == nr_r);

  for (genvar u = 0; u < UNROLL; u++) begin : g_stage
    logic [127:0] st_in_s;
    logic [127:0] st_out_s;
    logic [127:0] rkey_s;
    kwin_t        win_in_s;
    kwin_t        win_out_s;
    logic [5:0]   idx_in_s;
    logic [5:0]   idx_out_s;
    logic         last_s;

    if (u == 0) begin : g_first
      assign st_in_s  = state_r;
      assign win_in_s = win_r;
      assign idx_in_s = widx_r;
    end else begin : g_next
      assign st_in_s  = g_stage[u-1].st_out_s;
      assign win_in_s = g_stage[u-1].win_out_s;
      assign idx_in_s = g_stage[u-1].idx_out_s;
    end

    assign win_out_s = gen4(win_in_s, idx_in_s, kl_r);
    assign idx_out_s = idx_in_s + 6'd4;
    assign rkey_s    = round_key(win_out_s, kl_r);
    assign last_s    = ((rnd_r + 4'(u + 1)) == nr_r);

    aes_iter_encrypt_round u_round (
      .state_in  (st_in_s),
      .rkey      (rkey_s),
      .last      (last_s),
      .state_out (st_out_s)
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_r <= ST_IDLE;
    else     fsm_r <= fsm_nxt_s;
  end

  // FSM next state: accept in IDLE, iterate in RUN, hold result in DONE until taken.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (in_valid) fsm_nxt_s = ST_RUN;
        else          fsm_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (finish_s) fsm_nxt_s = ST_DONE;
        else          fsm_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) fsm_nxt_s = ST_IDLE;
        else           fsm_nxt_s = ST_DONE;
      end
      default: fsm_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: load round 0 on accept, advance UNROLL rounds per RUN clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= 128'h0;
      win_r      <= '0;
      widx_r     <= 6'd0;
      rnd_r      <= 4'd0;
      nr_r       <= 4'd0;
      kl_r       <= KL_128;
      cipher_r   <= 128'h0;
      rkey_dbg_r <= 128'h0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r    <= plain ^ key[255:128];
            win_r      <= load_window(key, kl_in_s);
            widx_r     <= nk_of(kl_in_s);
            rnd_r      <= 4'd0;
            nr_r       <= nr_of(kl_in_s);
            kl_r       <= kl_in_s;
            rkey_dbg_r <= key[255:128];
          end
        end
        ST_RUN: begin
          state_r    <= g_stage[UNROLL-1].st_out_s;
          win_r      <= g_stage[UNROLL-1].win_out_s;
          rnd_r      <= rnd_nxt_s;
          rkey_dbg_r <= g_stage[UNROLL-1].rkey_s;
          if (finish_s) cipher_r <= g_stage[UNROLL-1].st_out_s;
          else          widx_r   <= g_stage[UNROLL-1].idx_out_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (fsm_r == ST_IDLE);
  assign out_valid = (fsm_r == ST_DONE);
  assign cipher    = cipher_r;

  if (DBG_EN) begin : g_dbg
    assign dbg_round = rnd_r;
    assign dbg_state = state_r;
    assign dbg_rkey  = rkey_dbg_r;
  end else begin : g_nodbg
    assign dbg_round = 4'd0;
    assign dbg_state = 128'h0;
    assign dbg_rkey  = 128'h0;
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Scoreboard bench for aes_iter_encrypt, UNROLL=1 (index 0) and UNROLL=2 (index 1) instances.
module tb_aes_iter_encrypt;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [255:0] KB1  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PB1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB1  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [1:0]   key_len   [2];
  logic [127:0] plain     [2];
  logic [255:0] key       [2];
  logic [127:0] cipher    [2];
  logic [3:0]   dbg_round [2];
  logic [127:0] dbg_state [2];
  logic [127:0] dbg_rkey  [2];

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];
  logic [127:0] e0;
  logic [127:0] e1;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.UNROLL(1), .DBG_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .key_len(key_len[0]), .plain(plain[0]), .key(key[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .cipher(cipher[0]),
    .dbg_round(dbg_round[0]), .dbg_state(dbg_state[0]), .dbg_rkey(dbg_rkey[0])
  );

  aes_iter_encrypt #(.UNROLL(2), .DBG_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .key_len(key_len[1]), .plain(plain[1]), .key(key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .cipher(cipher[1]),
    .dbg_round(dbg_round[1]), .dbg_state(dbg_state[1]), .dbg_rkey(dbg_rkey[1])
  );

  // Scoreboard for the UNROLL=1 instance: compare on each output handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid[0] === 1'b1 && out_ready[0] === 1'b1) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_out got %h expected none", cipher[0]);
      end else begin
        e0 = exp_q0.pop_front();
        if (cipher[0] !== e0) begin
          errors++;
          $display("FAIL u1_cipher got %h expected %h", cipher[0], e0);
        end
      end
    end
  end

  // Scoreboard for the UNROLL=2 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid[1] === 1'b1 && out_ready[1] === 1'b1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL u2_unexpected_out got %h expected none", cipher[1]);
      end else begin
        e1 = exp_q1.pop_front();
        if (cipher[1] !== e1) begin
          errors++;
          $display("FAIL u2_cipher got %h expected %h", cipher[1], e1);
        end
      end
    end
  end

  // Drives one block (from posedge+1), pushes its expectation, returns just after the accept edge.
  task automatic send(input int d, input logic [1:0] kl, input logic [255:0] k,
                      input logic [127:0] p, input logic [127:0] e, input bit hold);
    bit acc;
    acc = 1'b0;
    in_valid[d] = 1'b1;
    key_len[d]  = kl;
    key[d]      = k;
    plain[d]    = p;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready[d] === 1'b1) begin
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut %0d in_ready stayed low", d);
    end
    if (!hold) in_valid[d] = 1'b0;
  endtask

  // Counts clocks after the accept edge until out_valid is seen.
  task automatic wait_out(input int d, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout dut %0d out_valid never rose", d);
    end
  endtask

  // Waits for the scoreboard queue of one instance to empty.
  task automatic wait_drain(input int d);
    int left;
    left = 0;
    for (int n = 0; n < 200; n++) begin
      left = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL drain dut %0d outstanding %0d expected 0", d, left);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; key_len[d] = 2'd0;
      plain[d] = 128'h0; key[d] = 256'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut %0d got %b expected 1", d, in_ready[d]); end
      checks++;
      if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut %0d got %b expected 0", d, out_valid[d]); end
      checks++;
      if (cipher[d] !== 128'h0) begin errors++; $display("FAIL reset_cipher dut %0d got %h expected 0", d, cipher[d]); end
      checks++;
      if ({dbg_round[d], dbg_state[d], dbg_rkey[d]} !== 260'h0) begin
        errors++; $display("FAIL reset_dbg dut %0d got %h/%h/%h expected 0", d, dbg_round[d], dbg_state[d], dbg_rkey[d]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips();
    int cyc;
    send(0, 2'd0, K128, PT, C1, 1'b0);
    wait_out(0, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL c1_latency got %0d expected 10", cyc); end
    send(0, 2'd1, K192, PT, C2, 1'b0);
    wait_out(0, cyc);
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL c2_latency got %0d expected 12", cyc); end
    send(0, 2'd2, K256, PT, C3, 1'b0);
    wait_out(0, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL c3_latency got %0d expected 14", cyc); end
    checks++;
    if (dbg_round[0] !== 4'd14) begin errors++; $display("FAIL c3_dbg_round got %0d expected 14", dbg_round[0]); end
    checks++;
    if (dbg_rkey[0] !== RK14) begin errors++; $display("FAIL c3_dbg_rkey got %h expected %h", dbg_rkey[0], RK14); end
    checks++;
    if (dbg_state[0] !== C3) begin errors++; $display("FAIL c3_dbg_state got %h expected %h", dbg_state[0], C3); end
    wait_drain(0);
  endtask

  task automatic test_unroll2();
    int cyc;
    send(1, 2'd0, K128, PT, C1, 1'b0);
    wait_out(1, cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL u2_c1_latency got %0d expected 5", cyc); end
    send(1, 2'd2, K256, PT, C3, 1'b0);
    wait_out(1, cyc);
    checks++;
    if (cyc !== 7) begin errors++; $display("FAIL u2_c3_latency got %0d expected 7", cyc); end
    checks++;
    if (dbg_rkey[1] !== RK14) begin errors++; $display("FAIL u2_c3_dbg_rkey got %h expected %h", dbg_rkey[1], RK14); end
    wait_drain(1);
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready[0] = 1'b0;
    send(0, 2'd0, K128, PT, C1, 1'b0);
    wait_out(0, cyc);
    for (int n = 0; n < 5; n++) begin
      in_valid[0] = 1'b1; key_len[0] = 2'd0; key[0] = KB1; plain[0] = PB1;
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b expected 1", n, out_valid[0]); end
      checks++;
      if (cipher[0] !== C1) begin errors++; $display("FAIL bp_cipher cyc %0d got %h expected %h", n, cipher[0], C1); end
      checks++;
      if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b expected 0", n, in_ready[0]); end
      @(posedge clk);
      #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid %b ready %b expected 0 1", out_valid[0], in_ready[0]);
    end
    repeat (20) @(posedge clk);
    #1;
    wait_drain(0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int cyc;
    send(0, 2'd2, K256, PT, C3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b expected 1", in_ready[0]); end
    checks++;
    if (dbg_round[0] !== 4'd0) begin errors++; $display("FAIL midrst_dbg_round got %0d expected 0", dbg_round[0]); end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid[0] === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_out_valid got 1 expected never"); end
    @(posedge clk);
    #1;
    send(0, 2'd0, KB1, PB1, CB1, 1'b0);
    wait_out(0, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL b1_latency got %0d expected 10", cyc); end
    send(0, 2'd3, K256, PT, C3, 1'b0);
    wait_out(0, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL kl3_latency got %0d expected 14", cyc); end
    wait_drain(0);
  endtask

  task automatic b2b_seq(input int d);
    out_ready[d] = 1'b1;
    send(d, 2'd0, K128, PT, C1, 1'b1);
    send(d, 2'd1, K192, PT, C2, 1'b1);
    send(d, 2'd2, K256, PT, C3, 1'b0);
    wait_drain(d);
  endtask

  task automatic test_back_to_back();
    fork
      b2b_seq(0);
      b2b_seq(1);
    join
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_unroll2();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
